// File: rtl/fetch_pipe.sv
// Instruction fetch front end: issues sequential fetches under a credit limit,
// buffers in-order responses with their PCs, and squashes wrong-path data on redirect.
module fetch_pipe #(
   parameter int              XLEN      = 16,
   parameter int              INST_W    = 16,
   parameter int              PC_STEP   = 2,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int              BUF_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   input  logic              halt,
   output logic              mem_req_valid,
   output logic [XLEN-1:0]   mem_req_addr,
   input  logic              mem_req_ready,
   input  logic              mem_rsp_valid,
   input  logic [INST_W-1:0] mem_rsp_data,
   input  logic              mem_rsp_err,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst,
   output logic [XLEN-1:0]   inst_pc,
   output logic              inst_err,
   input  logic              inst_ready,
   output logic [XLEN-1:0]   pc,
   output logic              err
);

   localparam int              PTR_W   = $clog2(BUF_DEPTH);
   localparam int              CNT_W   = $clog2(BUF_DEPTH + 1);
   localparam logic [XLEN-1:0] STEP    = XLEN'(PC_STEP);
   localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(BUF_DEPTH);

   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]   rsp_pc_q,   rsp_pc_d;
   logic [CNT_W-1:0]  outst_q,    outst_d;
   logic [CNT_W-1:0]  drop_q,     drop_d;
   logic [CNT_W-1:0]  count_q,    count_d;
   logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
   logic              err_q,      err_d;

   logic [INST_W-1:0] buf_data_q [BUF_DEPTH];
   logic [XLEN-1:0]   buf_pc_q   [BUF_DEPTH];
   logic              buf_err_q  [BUF_DEPTH];

   logic accept;
   logic rsp_drop;
   logic push;
   logic pop;
   logic credit_ok;

   // Every in-flight request already owns a buffer slot, so a response can never find the buffer full.
   assign credit_ok     = ({1'b0, outst_q} + {1'b0, count_q}) < DEPTH_C;
   assign mem_req_valid = !rst && !halt && !redirect_valid && !err_q && credit_ok;
   assign mem_req_addr  = fetch_pc_q;
   assign accept        = mem_req_valid && mem_req_ready;

   assign rsp_drop      = mem_rsp_valid && (drop_q != '0);
   assign push          = mem_rsp_valid && !rsp_drop && !redirect_valid;

   assign inst_valid    = (count_q != '0) && !redirect_valid;
   assign pop           = inst_valid && inst_ready;
   assign inst          = buf_data_q[rd_ptr_q];
   assign inst_pc       = buf_pc_q[rd_ptr_q];
   assign inst_err      = buf_err_q[rd_ptr_q];

   assign pc            = fetch_pc_q;
   assign err           = err_q;

   always_comb begin
      // NOTE: every next-state signal takes its hold value first so no path can infer a latch.
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      outst_d    = outst_q;
      drop_d     = drop_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      err_d      = err_q;

      unique case ({accept, mem_rsp_valid})
         2'b10:   outst_d = outst_q + CNT_W'(1);
         2'b01:   outst_d = outst_q - CNT_W'(1);
         default: outst_d = outst_q;
      endcase

      if (redirect_valid) begin
         // Everything still in flight belongs to the old path and must be discarded.
         fetch_pc_d = redirect_pc;
         rsp_pc_d   = redirect_pc;
         drop_d     = outst_d;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         err_d      = 1'b0;
      end else begin
         if (accept) begin
            fetch_pc_d = fetch_pc_q + STEP;
         end
         if (rsp_drop) begin
            drop_d = drop_q - CNT_W'(1);
         end
         if (push) begin
            rsp_pc_d = rsp_pc_q + STEP;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (mem_rsp_err) begin
               err_d = 1'b1;
            end
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         outst_q    <= '0;
         drop_q     <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         err_q      <= err_d;
      end
   end

   // NOTE: buffer storage has no reset; count_q alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_data_q[wr_ptr_q] <= mem_rsp_data;
         buf_pc_q[wr_ptr_q]   <= rsp_pc_q;
         buf_err_q[wr_ptr_q]  <= mem_rsp_err;
      end
   end

endmodule

// File: tb/tb_fetch_pipe.sv
// Directed bench for fetch_pipe: an in-order memory with programmable latency
// feeds the DUT while delivered instructions are logged and compared to hand-derived values.
module tb_fetch_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        halt;
   logic        mem_req_valid;
   logic [15:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_rsp_valid;
   logic [15:0] mem_rsp_data;
   logic        mem_rsp_err;
   logic        inst_valid;
   logic [15:0] inst;
   logic [15:0] inst_pc;
   logic        inst_err;
   logic        inst_ready;
   logic [15:0] pc;
   logic        err;

   always #5 clk = ~clk;

   fetch_pipe dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_req_ready  (mem_req_ready),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .mem_rsp_err    (mem_rsp_err),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_err       (inst_err),
      .inst_ready     (inst_ready),
      .pc             (pc),
      .err            (err)
   );

   typedef struct {
      logic [15:0] addr;
      int          due;
   } req_t;

   req_t        pend_q[$];
   logic [15:0] dl_pc[$];
   logic [15:0] dl_data[$];
   logic        dl_err[$];

   int          total = 0;
   int          bad   = 0;
   int          cyc;
   int          lat;
   int          n_acc;
   int          first_acc;
   int          first_inst;
   logic        s_req_v;
   logic [15:0] s_req_a;
   logic        s_inst_v;
   logic [15:0] err_addr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] dpc(input int i);
      return (dl_pc.size() > i) ? dl_pc[i] : 16'hDEAD;
   endfunction

   // One clock: memory answers due requests, outputs are sampled, then the edge is taken.
   task automatic cycle();
      req_t r;
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
         r             = pend_q.pop_front();
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = r.addr ^ 16'hC3C3;
         mem_rsp_err   = (r.addr == err_addr);
      end
      #1;
      s_req_v  = mem_req_valid;
      s_req_a  = mem_req_addr;
      s_inst_v = inst_valid;
      if (mem_req_valid && mem_req_ready) begin
         pend_q.push_back('{addr: mem_req_addr, due: cyc + lat});
         n_acc++;
         if (first_acc < 0) first_acc = cyc;
      end
      if (inst_valid && first_inst < 0) first_inst = cyc;
      if (inst_valid && inst_ready) begin
         dl_pc.push_back(inst_pc);
         dl_data.push_back(inst);
         dl_err.push_back(inst_err);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_req_valid", 32'(mem_req_valid), 32'h0);
      check("rst_inst_valid", 32'(inst_valid), 32'h0);
      check("rst_pc", 32'(pc), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      halt           = 1'b0;
      mem_rsp_valid  = 1'b0;
      mem_rsp_err    = 1'b0;
      pend_q.delete();
      dl_pc.delete();
      dl_data.delete();
      dl_err.delete();
      n_acc      = 0;
      first_acc  = -1;
      first_inst = -1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      halt           = 1'b0;
      mem_req_ready  = 1'b1;
      mem_rsp_valid  = 1'b0;
      mem_rsp_data   = '0;
      mem_rsp_err    = 1'b0;
      inst_ready     = 1'b1;
      err_addr       = 16'hFFFF;
      lat            = 1;
      cyc            = 0;

      // Sequential streaming, latency 1.
      do_reset();
      cycles(8);
      check("seq_pc0", 32'(dpc(0)), 32'h0000);
      check("seq_pc1", 32'(dpc(1)), 32'h0002);
      check("seq_pc2", 32'(dpc(2)), 32'h0004);
      check("seq_pc3", 32'(dpc(3)), 32'h0006);
      check("seq_first_latency", 32'(first_inst - first_acc), 32'd2);

      // Back-pressure: credit limit stops issue at BUF_DEPTH, pop releases one slot.
      inst_ready = 1'b0;
      do_reset();
      cycles(8);
      check("bp_accepts", 32'(n_acc), 32'd4);
      check("bp_req_blocked", 32'(s_req_v), 32'h0);
      check("bp_head_valid", 32'(inst_valid), 32'h1);
      check("bp_head_pc", 32'(inst_pc), 32'h0000);
      check("bp_fetch_pc", 32'(pc), 32'h0008);
      inst_ready = 1'b1;
      cycle();
      inst_ready = 1'b0;
      cycle();
      check("bp_resume_valid", 32'(s_req_v), 32'h1);
      check("bp_resume_addr", 32'(s_req_a), 32'h0008);
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0040;
      cycle();
      check("redir_inst_forced_low", 32'(s_inst_v), 32'h0);
      redirect_valid = 1'b0;
      #1;
      check("redir_flushed", 32'(inst_valid), 32'h0);
      check("redir_pc", 32'(pc), 32'h0040);

      // Redirect with three requests in flight at latency 3.
      inst_ready = 1'b1;
      lat        = 3;
      do_reset();
      cycles(3);
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0100;
      cycle();
      redirect_valid = 1'b0;
      cycles(8);
      check("drop_first_pc", 32'(dpc(0)), 32'h0100);
      check("drop_first_data", 32'(dl_data.size() > 0 ? dl_data[0] : 16'hDEAD), 32'hC2C3);
      check("drop_second_pc", 32'(dpc(1)), 32'h0102);

      // PC wrap at the top of the address space.
      lat = 1;
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 16'hFFFE;
      cycle();
      redirect_valid = 1'b0;
      check("wrap_pc_before", 32'(pc), 32'hFFFE);
      cycle();
      check("wrap_pc_after", 32'(pc), 32'h0000);
      cycles(3);
      check("wrap_inst0", 32'(dpc(0)), 32'hFFFE);
      check("wrap_inst1", 32'(dpc(1)), 32'h0000);

      // Error response at 0x0008 stops issue until a redirect.
      err_addr = 16'h0008;
      do_reset();
      cycles(10);
      check("err_inst_pc", 32'(dpc(4)), 32'h0008);
      check("err_inst_flag", 32'(dl_err.size() > 4 ? dl_err[4] : 1'b0), 32'h1);
      check("err_inflight_buffered", 32'(dpc(5)), 32'h000A);
      check("err_next_flag", 32'(dl_err.size() > 5 ? dl_err[5] : 1'b1), 32'h0);
      check("err_accepts", 32'(n_acc), 32'd6);
      check("err_req_blocked", 32'(s_req_v), 32'h0);
      check("err_sticky", 32'(err), 32'h1);
      err_addr       = 16'hFFFF;
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0200;
      cycle();
      redirect_valid = 1'b0;
      #1;
      check("err_cleared", 32'(err), 32'h0);
      cycle();
      check("err_resume_valid", 32'(s_req_v), 32'h1);
      check("err_resume_addr", 32'(s_req_a), 32'h0200);

      // Halt with two outstanding requests.
      lat = 3;
      do_reset();
      cycles(2);
      halt = 1'b1;
      cycles(5);
      check("halt_accepts", 32'(n_acc), 32'd2);
      check("halt_delivered", 32'(dl_pc.size()), 32'd2);
      check("halt_inst0", 32'(dpc(0)), 32'h0000);
      check("halt_inst1", 32'(dpc(1)), 32'h0002);
      check("halt_pc", 32'(pc), 32'h0004);
      halt = 1'b0;
      cycle();
      check("halt_resume_valid", 32'(s_req_v), 32'h1);
      check("halt_resume_addr", 32'(s_req_a), 32'h0004);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
